// File: rtl/mult_share_arb.sv
// Round-robin sequencer that shares one pipelined 16x16 multiplier among N_REQ
// requesters and routes each product back to its issuer via a tag pipeline.
module mult_share_arb #(
    parameter int N_REQ    = 4,
    parameter int MULT_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [16*N_REQ-1:0]   req_x,
    input  logic [16*N_REQ-1:0]   req_y,
    output logic [15:0]           mult_x,
    output logic [15:0]           mult_y,
    input  logic [31:0]           mult_p,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [31:0]           resp_p,
    output logic                  idle
);

    localparam int PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int STAGES = MULT_LAT + 1;

    typedef struct packed {
        logic          vld;
        logic [PW-1:0] id;
    } tag_t;

    logic [PW-1:0]           ptr_q, ptr_d;
    logic [15:0]             mx_q, my_q;
    tag_t [STAGES-1:0]       tag_q;
    logic [N_REQ-1:0]        resp_valid_q, resp_valid_d;
    logic [31:0]             resp_p_q;

    logic                    found;
    logic [PW-1:0]           win;
    logic [N_REQ-1:0]        gnt;
    logic [15:0]             sel_x, sel_y;
    logic                    tags_any;
    tag_t                    tag_out;

    // Rotating priority search: first valid requester at or after the pointer.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (found) gnt[win] = 1'b1;
    end

    assign req_ready = rst_n ? gnt : '0;
    assign sel_x     = req_x[16*win +: 16];
    assign sel_y     = req_y[16*win +: 16];

    always_comb begin
        ptr_d = ptr_q;
        if (found) ptr_d = (win == PW'(N_REQ-1)) ? '0 : win + PW'(1);
    end

    assign tag_out = tag_q[STAGES-1];

    always_comb begin
        resp_valid_d = '0;
        if (tag_out.vld) resp_valid_d[tag_out.id] = 1'b1;
    end

    always_comb begin
        tags_any = 1'b0;
        for (int s = 0; s < STAGES; s++) tags_any = tags_any | tag_q[s].vld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            mx_q         <= '0;
            my_q         <= '0;
            tag_q        <= '0;
            resp_valid_q <= '0;
            resp_p_q     <= '0;
        end else begin
            ptr_q <= ptr_d;
            // Operands hold when nothing is granted so the multiplier sees no toggling.
            if (found) begin
                mx_q <= sel_x;
                my_q <= sel_y;
            end
            tag_q[0] <= '{vld: found, id: win};
            for (int s = 1; s < STAGES; s++) tag_q[s] <= tag_q[s-1];
            resp_valid_q <= resp_valid_d;
            if (tag_out.vld) resp_p_q <= mult_p;
        end
    end

    assign mult_x     = mx_q;
    assign mult_y     = my_q;
    assign resp_valid = resp_valid_q;
    assign resp_p     = resp_p_q;
    assign idle       = ~tags_any & ~(|req_valid);

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with an exact 2-stage multiplier model.
module tb_mult_share_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_x = '0;
    logic [63:0] req_y = '0;
    logic [15:0] mult_x, mult_y;
    logic [31:0] mult_p;
    logic [3:0]  resp_valid;
    logic [31:0] resp_p;
    logic        idle;

    int nvec = 0;
    int nerr = 0;

    mult_share_arb #(.N_REQ(4), .MULT_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .mult_x(mult_x), .mult_y(mult_y),
        .mult_p(mult_p), .resp_valid(resp_valid), .resp_p(resp_p), .idle(idle)
    );

    always #5 clk = ~clk;

    // Registered-input, registered-output exact multiplier.
    logic [15:0] ma = '0, mb = '0;
    logic [31:0] mp = '0;
    always @(posedge clk) begin
        ma <= mult_x;
        mb <= mult_y;
        mp <= ma * mb;
    end
    assign mult_p = mp;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        req_valid = 4'hF;
        step();
        #1;
        nvec++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        nvec++; if (resp_valid !== 4'b0000) begin nerr++; $display("FAIL reset_resp_valid got %b exp 0000", resp_valid); end
        nvec++; if (mult_x !== 16'h0) begin nerr++; $display("FAIL reset_mult_x got %h exp 0000", mult_x); end
        nvec++; if (mult_y !== 16'h0) begin nerr++; $display("FAIL reset_mult_y got %h exp 0000", mult_y); end
        nvec++; if (idle !== 1'b0) begin nerr++; $display("FAIL reset_idle_busy got %b exp 0", idle); end
        step();
        rst_n = 1'b1;
        req_valid = 4'b0000;
        #1;
        nvec++; if (idle !== 1'b1) begin nerr++; $display("FAIL reset_idle got %b exp 1", idle); end
    endtask

    task automatic test_single();
        step();
        req_valid = 4'b0100;
        req_x[47:32] = 16'd3;
        req_y[47:32] = 16'd5;
        #1;
        nvec++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL single_ready got %b exp 0100", req_ready); end
        for (int k = 1; k <= 6; k++) begin
            step();
            req_valid = 4'b0000;
            #1;
            if (k == 1) begin
                nvec++; if (mult_x !== 16'd3) begin nerr++; $display("FAIL single_mult_x got %h exp 0003", mult_x); end
            end
            nvec++;
            if (resp_valid !== ((k == 4) ? 4'b0100 : 4'b0000)) begin
                nerr++; $display("FAIL single_resp_valid cycle %0d got %b", k, resp_valid);
            end
            if (k == 4) begin
                nvec++; if (resp_p !== 32'd15) begin nerr++; $display("FAIL single_resp_p got %0d exp 15", resp_p); end
            end
        end
    endtask

    task automatic test_wrap();
        step();
        req_valid = 4'b1000;
        #1;
        nvec++; if (req_ready !== 4'b1000) begin nerr++; $display("FAIL wrap_first got %b exp 1000", req_ready); end
        step();
        req_valid = 4'b1001;
        #1;
        nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL wrap_to_zero got %b exp 0001", req_ready); end
        step();
        req_valid = 4'b1000;
        #1;
        nvec++; if (req_ready !== 4'b1000) begin nerr++; $display("FAIL wrap_then_three got %b exp 1000", req_ready); end
        step();
        req_valid = 4'b0000;
        repeat (6) step();
    endtask

    task automatic test_contention();
        logic [3:0] e;
        for (int i = 0; i < 4; i++) begin
            req_x[16*i +: 16] = 16'(i + 1);
            req_y[16*i +: 16] = 16'd2;
        end
        for (int k = 0; k < 12; k++) begin
            step();
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            e = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
            nvec++; if (req_ready !== e) begin nerr++; $display("FAIL contention_ready cycle %0d got %b exp %b", k, req_ready, e); end
            e = (k >= 4) ? (4'b0001 << ((k - 4) % 4)) : 4'b0000;
            nvec++; if (resp_valid !== e) begin nerr++; $display("FAIL contention_resp_valid cycle %0d got %b exp %b", k, resp_valid, e); end
            if (k >= 4) begin
                nvec++;
                if (resp_p !== 32'(2 * ((k - 4) % 4 + 1))) begin
                    nerr++; $display("FAIL contention_resp_p cycle %0d got %0d exp %0d", k, resp_p, 2 * ((k - 4) % 4 + 1));
                end
            end
            if (k == 10 || k == 11) begin
                nvec++;
                if (idle !== (k == 11)) begin nerr++; $display("FAIL contention_idle cycle %0d got %b", k, idle); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k < 3) begin
                req_valid = 4'b0010;
                req_x[31:16] = 16'(k + 1);
                req_y[31:16] = 16'(k + 1);
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            if (k < 3) begin
                nvec++; if (req_ready !== 4'b0010) begin nerr++; $display("FAIL b2b_ready cycle %0d got %b exp 0010", k, req_ready); end
            end
            e = (k >= 4 && k <= 6) ? 4'b0010 : 4'b0000;
            nvec++; if (resp_valid !== e) begin nerr++; $display("FAIL b2b_resp_valid cycle %0d got %b exp %b", k, resp_valid, e); end
            if (k >= 4 && k <= 6) begin
                nvec++;
                if (resp_p !== 32'((k - 3) * (k - 3))) begin
                    nerr++; $display("FAIL b2b_resp_p cycle %0d got %0d exp %0d", k, resp_p, (k - 3) * (k - 3));
                end
            end
        end
    endtask

    task automatic test_midreset();
        step();
        req_valid = 4'b0101;
        req_x[15:0] = 16'd7;  req_y[15:0] = 16'd7;
        req_x[47:32] = 16'd9; req_y[47:32] = 16'd9;
        #1;
        nvec++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL midrst_grant2 got %b exp 0100", req_ready); end
        step();
        req_valid = 4'b0001;
        #1;
        nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL midrst_grant0 got %b exp 0001", req_ready); end
        step();
        req_valid = 4'b0000;
        rst_n = 1'b0;
        #1;
        nvec++; if (mult_x !== 16'h0) begin nerr++; $display("FAIL midrst_mult_x got %h exp 0000", mult_x); end
        nvec++; if (mult_y !== 16'h0) begin nerr++; $display("FAIL midrst_mult_y got %h exp 0000", mult_y); end
        nvec++; if (resp_p !== 32'h0) begin nerr++; $display("FAIL midrst_resp_p got %h exp 0", resp_p); end
        nvec++; if (resp_valid !== 4'b0000) begin nerr++; $display("FAIL midrst_resp_valid got %b exp 0000", resp_valid); end
        nvec++; if (idle !== 1'b1) begin nerr++; $display("FAIL midrst_idle got %b exp 1", idle); end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            #1;
            nvec++; if (resp_valid !== 4'b0000) begin nerr++; $display("FAIL midrst_no_resp cycle %0d got %b", k, resp_valid); end
        end
        step();
        req_valid = 4'b1001;
        #1;
        nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL midrst_ptr_restart got %b exp 0001", req_ready); end
        step();
        req_valid = 4'b1000;
        #1;
        nvec++; if (req_ready !== 4'b1000) begin nerr++; $display("FAIL midrst_second got %b exp 1000", req_ready); end
        step();
        req_valid = 4'b0000;
        repeat (6) step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_contention();
        test_back_to_back();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one registered 16x16 approximate multiplier among N_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle to the multiplier.
- Tracks each in-flight product with a requester tag through a latency-matched pipeline, then returns the 32-bit product to the originating requester.
- Sits between the accelerator's client ports and the shared multiplier instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MULT_LAT, 2, cycles from operands driven on mult_x/mult_y to the matching product valid on mult_p (registered-input, registered-output multiplier gives 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester operand valid.
- req_ready  output  N_REQ  per-requester grant (one-hot or zero).
- req_x  input  16*N_REQ  packed X operands, requester i at [16i+15:16i].
- req_y  input  16*N_REQ  packed Y operands, same packing.
- mult_x  output  16  X operand to the shared multiplier.
- mult_y  output  16  Y operand to the shared multiplier.
- mult_p  input  32  product from the shared multiplier.
- resp_valid  output  N_REQ  one-hot, single-cycle result strobe.
- resp_p  output  32  result product, valid while any resp_valid bit is high.
- idle  output  1  high when nothing is in flight and no req_valid is high.

Behaviour:
- Reset (async assert, sync release):
  - mult_x = mult_y = 0, resp_valid = 0, resp_p = 0.
  - Round-robin pointer = 0; all tag-pipe stages invalid.
  - req_ready = 0 while rst_n is low.
- Arbitration (combinational, every cycle):
  - Search req_valid starting at the pointer, wrapping modulo N_REQ; the first set bit wins.
  - req_ready = one-hot of the winner, or 0 if no requester is valid.
  - Requesters must not make req_valid depend on req_ready.
  - Once asserted, req_valid and its operands must hold until handshake (valid & ready).
- Issue (cycle c is the handshake cycle, winner w):
  - At the end of cycle c: mult_x/mult_y <= req_x[w]/req_y[w]; tag stage 0 <= {valid = 1, id = w}; pointer <= (w+1) mod N_REQ.
  - No grant: mult_x/mult_y hold their previous values (no toggling when idle), tag stage 0 <= invalid, pointer unchanged.
- Tag pipeline:
  - MULT_LAT+1 register stages, shifting every cycle; no stall.
  - The last stage aligns with mult_p: the product for the cycle-c handshake is valid on mult_p in cycle c+1+MULT_LAT.
  - At the end of that cycle: resp_p <= mult_p and resp_valid <= onehot(id).
  - Result is visible in cycle c+2+MULT_LAT (4 cycles at default).
  - resp_p holds its last value when resp_valid = 0.
- Throughput and ordering:
  - One issue and one response per cycle sustained.
  - Responses return in issue order.
  - No response backpressure: requesters must accept resp_valid unconditionally.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,N_REQ-1,0,..; no requester waits more than N_REQ-1 grants.
- Boundary conditions:
  - Single requester continuously valid: granted every cycle.
  - Pointer wraps from N_REQ-1 to 0.
  - A requester may be granted again while its earlier product is still in flight; each product yields its own strobe.
- idle: high when no tag stage is valid and req_valid == 0, low otherwise. It is registered from the tag stages and combinational on req_valid.
- Reset mid-operation: all in-flight tags are discarded and no resp_valid is produced for them. After release, the pointer restarts at 0.

Test Plan:
- Reset: rst_n low with all req_valid = 1 -> req_ready = 0, resp_valid = 0, mult_x = 0, idle = 0. Release rst_n, drop req_valid -> idle = 1.
- Single op: req_valid[2] = 1, x = 0x0003, y = 0x0005 in cycle 0 -> req_ready = 4'b0100 in cycle 0, mult_x = 0x0003 in cycle 1, resp_valid = 4'b0100 and resp_p equal to the multiplier's 32-bit product for 3x5 (15 for an exact model) in cycle 4 only.
- Full contention: all four valid for 8 cycles with x = requester id + 1, y = 2 -> grants 0,1,2,3,0,1,2,3. resp_valid sequence is identical, delayed 4 cycles. resp_p = 2,4,6,8,... with an exact model.
- Back-to-back same requester: req_valid[1] held 3 cycles with operands (1,1), (2,2), (3,3) -> three consecutive resp_valid[1] strobes with resp_p = 1, 4, 9 in order.
- Pointer wrap: grant 3, then requesters 0 and 3 both valid -> requester 0 granted first.
- Mid-flight reset: issue 2 ops, assert rst_n for 1 cycle before they complete -> no resp_valid ever appears for them, and all outputs match the reset values.
